// File: rtl/music_box_sequencer_if.sv
// Song-ROM read bus between the music-box sequencer and the song memory.
// Read data is returned exactly one cycle after mem_rd is sampled high.
interface music_box_sequencer_if;
  logic [6:0] mem_addr;
  logic       mem_rd;
  logic [6:0] mem_data;

  modport master (output mem_addr, output mem_rd, input mem_data);
  modport slave  (input mem_addr, input mem_rd, output mem_data);
endinterface

// File: rtl/music_box_sequencer.sv
// Music-box playback controller: latches a song request, walks the song's instruction
// table one note at a time, times each note in beats and drives the note index.
module music_box_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 25_000_000,
  parameter int unsigned GAP_TICKS      = 2_500_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2:0]                   i_song_sel,
  input  logic                         i_start,
  input  logic                         i_stop,
  music_box_sequencer_if.master        mem,
  output logic [3:0]                   o_note_case,
  output logic                         o_note_on,
  output logic [1:0]                   o_cur_song,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int unsigned MAX_BEATS = 4 * TICKS_PER_BEAT;
  localparam int unsigned MAX_LOAD  = (GAP_TICKS > MAX_BEATS) ? GAP_TICKS : MAX_BEATS;
  localparam int unsigned CNT_W     = $clog2(MAX_LOAD + 1);
  localparam logic [3:0]  NOTE_REST = 4'd8;
  localparam logic [4:0]  LOC_LAST  = 5'd31;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t           r_state, w_state;
  logic [4:0]       r_loc, w_loc;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_start, w_start;
  logic [1:0]       r_sel_idx, w_sel_idx;
  logic [6:0]       r_mem_addr, w_mem_addr;
  logic             r_mem_rd, w_mem_rd;
  logic [3:0]       r_note_case, w_note_case;
  logic             r_note_on, w_note_on;
  logic [1:0]       r_cur_song, w_cur_song;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             w_adv;

  // Note length in clock cycles for a 2-bit duration code (code 0 = one beat).
  function automatic logic [CNT_W-1:0] beat_load(input logic [1:0] dur);
    logic [CNT_W-1:0] v;
    case (dur)
      2'd0:    v = CNT_W'(TICKS_PER_BEAT);
      2'd1:    v = CNT_W'(2 * TICKS_PER_BEAT);
      2'd2:    v = CNT_W'(3 * TICKS_PER_BEAT);
      default: v = CNT_W'(MAX_BEATS);
    endcase
    return v;
  endfunction

  // Request capture: start is registered together with the priority-encoded song.
  always_comb begin
    w_start   = i_start && !i_stop && (r_state == S_IDLE) && !r_start && (i_song_sel != 3'd0);
    w_sel_idx = 2'd2;
    if (i_song_sel[0])      w_sel_idx = 2'd0;
    else if (i_song_sel[1]) w_sel_idx = 2'd1;
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state     = r_state;
    w_loc       = r_loc;
    w_cnt       = r_cnt;
    w_mem_addr  = r_mem_addr;
    w_mem_rd    = 1'b0;
    w_note_case = r_note_case;
    w_note_on   = r_note_on;
    w_cur_song  = r_cur_song;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_adv       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_start) begin
          w_state    = S_FETCH;
          w_cur_song = r_sel_idx;
          w_loc      = 5'd1;
          w_mem_rd   = 1'b1;
          w_mem_addr = {r_sel_idx, 5'd1};
          w_busy     = 1'b1;
        end
      end
      S_FETCH: begin
        w_state = S_DECODE;
      end
      S_DECODE: begin
        if (mem.mem_data[6]) begin
          w_state     = S_PLAY;
          w_note_case = mem.mem_data[5:2];
          w_note_on   = 1'b1;
          w_cnt       = beat_load(mem.mem_data[1:0]);
        end else begin
          w_state     = S_DONE;
          w_done      = 1'b1;
          w_note_case = NOTE_REST;
          w_note_on   = 1'b0;
        end
      end
      S_PLAY: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_note_on   = 1'b0;
          w_note_case = NOTE_REST;
          if (GAP_TICKS != 0) begin
            w_state = S_GAP;
            w_cnt   = CNT_W'(GAP_TICKS);
          end else begin
            w_adv = 1'b1;
          end
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt <= CNT_W'(1)) w_adv = 1'b1;
        else                    w_cnt = r_cnt - CNT_W'(1);
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase

    // Advance to the next table entry; the table ends at location 31 without wrapping.
    if (w_adv) begin
      w_cnt = '0;
      if (r_loc == LOC_LAST) begin
        w_state     = S_DONE;
        w_done      = 1'b1;
        w_note_case = NOTE_REST;
        w_note_on   = 1'b0;
      end else begin
        w_state    = S_FETCH;
        w_loc      = r_loc + 5'd1;
        w_mem_rd   = 1'b1;
        w_mem_addr = {r_cur_song, r_loc + 5'd1};
      end
    end

    // Abort wins over everything else, including a same-cycle start.
    if (i_stop && (r_state != S_IDLE)) begin
      w_state     = S_IDLE;
      w_cnt       = '0;
      w_mem_rd    = 1'b0;
      w_note_case = NOTE_REST;
      w_note_on   = 1'b0;
      w_busy      = 1'b0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_loc       <= '0;
      r_cnt       <= '0;
      r_start     <= 1'b0;
      r_sel_idx   <= '0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_note_case <= NOTE_REST;
      r_note_on   <= 1'b0;
      r_cur_song  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_loc       <= w_loc;
      r_cnt       <= w_cnt;
      r_start     <= w_start;
      r_sel_idx   <= w_sel_idx;
      r_mem_addr  <= w_mem_addr;
      r_mem_rd    <= w_mem_rd;
      r_note_case <= w_note_case;
      r_note_on   <= w_note_on;
      r_cur_song  <= w_cur_song;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign mem.mem_addr = r_mem_addr;
  assign mem.mem_rd   = r_mem_rd;
  assign o_note_case  = r_note_case;
  assign o_note_on    = r_note_on;
  assign o_cur_song   = r_cur_song;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule
